// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver with mid-bit sampling and an AXI-Stream single-entry output register.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] ARM_CNT   = CNT_W'(2);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sample_c;
  logic                 deliver_c;
  logic                 frame_err_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_c;
`endif

  uart_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  assign sample_c = (cnt_q == '0);

  // State, counters and shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state, sampling and frame-result decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    deliver_c   = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_c = 1'b0;
`endif
    case (state_q)
      // Several consecutive highs, so the synchroniser's reset value is not read as idle.
      WAIT_HIGH: begin
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == ARM_CNT) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          bit_d   = '0;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!sample_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
        end
      end
      DATA: begin
        if (!sample_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!sample_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          par_bad_d    = (rx_s != ^shift_q);
          parity_err_c = par_bad_d;
          cnt_d        = FULL_LOAD;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (!sample_c) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          deliver_c = !par_bad_q;
`else
          deliver_c = 1'b1;
`endif
          state_d = IDLE;
        end else begin
          frame_err_c = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_HIGH;
        end
      end
      default: begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register, handshake and error pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_axis_tdata_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o    <= 1'b0;
`endif
    end else begin
      frame_err_o <= frame_err_c;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= parity_err_c;
`endif
      if (deliver_c) begin
        if (!m_axis_tvalid_o || m_axis_tready_i) begin
          m_axis_tdata_o  <= shift_q;
          m_axis_tvalid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event model plus per-cycle output compare.
// Build with UART_RX_PARITY_EN defined to exercise 8E1 frames.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // rx_i fall to outputs: 2 sync + CPB/2 + 9*CPB + 1 (+CPB with parity)
  localparam int unsigned LAT = PAR ? 171 : 155;

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int unsigned at;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic       tready;
  logic [7:0] tdata;
  logic       tvalid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rx_i            (rx_i),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .frame_err_o     (frame_err),
    .overrun_o       (overrun),
    .parity_err_o    (parity_err)
  );

  always #5 clk_i = ~clk_i;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  ev_t         ev_q[$];
  logic        m_valid = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic        e_ferr = 1'b0;
  logic        e_ovr = 1'b0;
  logic        e_perr = 1'b0;

  int          hs_cnt = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          perr_cnt = 0;
  logic [7:0]  got_q[$];
  logic        tvalid_prev = 1'b0;
  int unsigned rise_cyc = 0;
  int unsigned last_fall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: frame outcomes scheduled at absolute cycles, holding register follows the handshake.
  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    e_perr = 1'b0;
    if (!rst_ni) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      ev_q.delete();
    end else begin
      cyc++;
      if (m_valid && tready) m_valid = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        ev_t e;
        e = ev_q.pop_front();
        if (e.kind == K_DATA) begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = e.data;
          end else begin
            e_ovr = 1'b1;
          end
        end else if (e.kind == K_FERR) begin
          e_ferr = 1'b1;
        end else begin
          e_perr = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk_i);
    chk("tvalid", 32'(tvalid), 32'(m_valid));
    chk("tdata", 32'(tdata), 32'(m_data));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
    if (tvalid === 1'b1 && tready) begin
      hs_cnt++;
      got_q.push_back(tdata);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (tvalid === 1'b1 && !tvalid_prev) rise_cyc = cyc;
    tvalid_prev = (tvalid === 1'b1);
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_ev(input int unsigned at, input int kind, input logic [7:0] d);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    e.data = d;
    ev_q.push_back(e);
  endtask

  // One frame; expected outcome derived from the frame contents.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit par_ok);
    int unsigned f;
    logic        pb;
    @(posedge clk_i);
    #1;
    f         = cyc;
    last_fall = f;
    pb        = (^b) ^ !par_ok;
    if (PAR && !par_ok) push_ev(f + LAT - CPB, K_PERR, 8'h00);
    if (!stop_bit) push_ev(f + LAT, K_FERR, 8'h00);
    else if (!PAR || par_ok) push_ev(f + LAT, K_DATA, b);
    rx_i = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      hold(CPB);
    end
    if (PAR) begin
      rx_i = pb;
      hold(CPB);
    end
    rx_i = stop_bit;
    hold(CPB);
    rx_i = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_bytes [6];
    exp_bytes = '{8'hA5, 8'h3C, 8'h0F, 8'h11, 8'h81, 8'h03};
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    tready = 1'b1;
    hold(5);
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tdata", 32'(tdata), 32'd0);
    rst_ni = 1'b1;
    hold(30);

    // 1: plain byte, latency pinned
    send_frame(8'hA5, 1'b1, 1'b1);
    hold(10);
    chk("t1_latency", rise_cyc - last_fall, LAT);
    chk("t1_handshakes", hs_cnt, 1);

    // 2: short low glitch is rejected
    rx_i = 1'b0;
    hold(4);
    rx_i = 1'b1;
    hold(40);
    chk("t2_glitch_no_byte", hs_cnt, 1);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(10);

    // 3: stop bit low -> frame error, byte dropped
    send_frame(8'h55, 1'b0, 1'b1);
    hold(20);
    chk("t3_ferr_count", ferr_cnt, 1);
    chk("t3_no_byte", hs_cnt, 2);
    send_frame(8'h0F, 1'b1, 1'b1);
    hold(10);

    // 4: backpressure and overrun
    tready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    hold(5);
    send_frame(8'h22, 1'b1, 1'b1);
    hold(10);
    chk("t4_held_valid", 32'(tvalid), 32'd1);
    chk("t4_held_data", 32'(tdata), 32'h11);
    chk("t4_overrun_count", ovr_cnt, 1);
    tready = 1'b1;
    hold(5);
    chk("t4_handshakes", hs_cnt, 4);

    // 5: reset mid-frame with line low
    rx_i = 1'b0;
    hold(CPB * 4 + 8);
    rst_ni = 1'b0;
    hold(3);
    rst_ni = 1'b1;
    hold(100);
    chk("t5_no_start_valid", 32'(tvalid), 32'd0);
    chk("t5_no_ferr", ferr_cnt, 1);
    rx_i = 1'b1;
    hold(40);
    send_frame(8'h81, 1'b1, 1'b1);
    hold(10);
    chk("t5_handshakes", hs_cnt, 5);

    // 6: parity error then good parity
    if (PAR) begin
      send_frame(8'h03, 1'b1, 1'b0);
      hold(10);
      chk("t6_perr_count", perr_cnt, 1);
      chk("t6_no_byte", hs_cnt, 5);
      send_frame(8'h03, 1'b1, 1'b1);
      hold(10);
    end

    chk("total_handshakes", hs_cnt, PAR ? 6 : 5);
    chk("total_ferr", ferr_cnt, 1);
    chk("total_overrun", ovr_cnt, 1);
    chk("total_perr", perr_cnt, PAR ? 1 : 0);
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_bytes[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
